// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit between the core memory stage and a
// word-addressed data memory. One request at a time over valid/ready.
// Loads extract a byte/half lane and sign- or zero-extend it. Sub-word
// stores do a read-modify-write. A one-cycle response carries the read
// data or an error flag.
// Ports:
//   clk, reset                  clock, async active-high reset
//   req_valid/req_ready         request handshake (ready only in IDLE)
//   req_write, req_size,
//   req_unsigned, req_addr,
//   req_wdata                   request fields (byte address)
//   mem_we/mem_waddr/mem_wdata  memory write port (word aligned)
//   mem_re/mem_raddr/mem_rdata  memory read port (word aligned)
//   resp_valid/resp_rdata/
//   resp_err                    one-cycle response
// Optional: define MEM_ACCESS_RANGE_CHECK_EN to flag addresses at or
// beyond MEM_WORDS*4 as errors without touching memory.
module mem_access_unit #(
   parameter int XLEN       = 32,
   parameter int ADDRESSLEN = 32,
   parameter int MEM_WORDS  = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [ADDRESSLEN-1:0] req_addr,
   input  logic [XLEN-1:0]       req_wdata,
   output logic                  mem_we,
   output logic [ADDRESSLEN-1:0] mem_waddr,
   output logic [XLEN-1:0]       mem_wdata,
   output logic                  mem_re,
   output logic [ADDRESSLEN-1:0] mem_raddr,
   input  logic [XLEN-1:0]       mem_rdata,
   output logic                  resp_valid,
   output logic [XLEN-1:0]       resp_rdata,
   output logic                  resp_err
);

   typedef enum logic [1:0] {
      IDLE,
      RD,
      WR,
      RESP
   } state_t;

`ifdef MEM_ACCESS_RANGE_CHECK_EN
   localparam bit RANGE_EN = 1'b1;
`else
   localparam bit RANGE_EN = 1'b0;
`endif

   localparam logic [63:0] MEM_BYTES = 64'(MEM_WORDS) * 64'd4;

   state_t state_q, state_d;

   logic       write_q, write_d;
   logic [1:0] size_q, size_d;
   logic       uns_q, uns_d;
   logic [1:0] off_q, off_d;
   logic [15:0] wdata_q, wdata_d;

   logic                  mem_we_q, mem_we_d;
   logic [ADDRESSLEN-1:0] mem_waddr_q, mem_waddr_d;
   logic [XLEN-1:0]       mem_wdata_q, mem_wdata_d;
   logic                  mem_re_q, mem_re_d;
   logic [ADDRESSLEN-1:0] mem_raddr_q, mem_raddr_d;
   logic                  resp_valid_q, resp_valid_d;
   logic [XLEN-1:0]       resp_rdata_q, resp_rdata_d;
   logic                  resp_err_q, resp_err_d;

   logic                  req_err;
   logic                  range_hit;
   logic [ADDRESSLEN-1:0] word_addr;
   logic [4:0]            lane_sh;
   logic [7:0]            lane_b;
   logic [15:0]           lane_h;
   logic [XLEN-1:0]       load_ext;
   logic [XLEN-1:0]       lane_mask;
   logic [XLEN-1:0]       merged;

   assign word_addr = {req_addr[ADDRESSLEN-1:2], 2'b00};
   assign range_hit = (64'(req_addr) >= MEM_BYTES);

   always_comb begin
      req_err = 1'b0;
      unique case (req_size)
         2'b00:   req_err = 1'b0;
         2'b01:   req_err = req_addr[0];
         2'b10:   req_err = |req_addr[1:0];
         default: req_err = 1'b1;
      endcase
      if (RANGE_EN && range_hit)
         req_err = 1'b1;
   end

   // Half lanes always have off_q[0]=0, so one byte-granular shift
   // serves both lane widths.
   assign lane_sh = {off_q, 3'b000};
   assign lane_b  = 8'(mem_rdata >> lane_sh);
   assign lane_h  = 16'(mem_rdata >> lane_sh);

   always_comb begin
      load_ext = mem_rdata;
      unique case (size_q)
         2'b00:   load_ext = {{(XLEN-8){~uns_q & lane_b[7]}}, lane_b};
         2'b01:   load_ext = {{(XLEN-16){~uns_q & lane_h[15]}}, lane_h};
         default: load_ext = mem_rdata;
      endcase
   end

   assign lane_mask = ((size_q == 2'b00) ? XLEN'(8'hFF)
                                         : XLEN'(16'hFFFF)) << lane_sh;
   assign merged = (mem_rdata & ~lane_mask)
                 | ((XLEN'(wdata_q) << lane_sh) & lane_mask);

   always_comb begin
      state_d      = state_q;
      write_d      = write_q;
      size_d       = size_q;
      uns_d        = uns_q;
      off_d        = off_q;
      wdata_d      = wdata_q;
      mem_waddr_d  = mem_waddr_q;
      mem_wdata_d  = mem_wdata_q;
      mem_raddr_d  = mem_raddr_q;
      mem_we_d     = 1'b0;
      mem_re_d     = 1'b0;
      resp_valid_d = 1'b0;
      resp_rdata_d = '0;
      resp_err_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               write_d = req_write;
               size_d  = req_size;
               uns_d   = req_unsigned;
               off_d   = req_addr[1:0];
               wdata_d = req_wdata[15:0];
               if (req_err) begin
                  state_d      = RESP;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
               end else if (req_write && req_size == 2'b10) begin
                  state_d     = WR;
                  mem_we_d    = 1'b1;
                  mem_waddr_d = word_addr;
                  mem_wdata_d = req_wdata;
               end else begin
                  state_d     = RD;
                  mem_re_d    = 1'b1;
                  mem_raddr_d = word_addr;
               end
            end
         end
         RD: begin
            if (write_q) begin
               state_d     = WR;
               mem_we_d    = 1'b1;
               mem_waddr_d = mem_raddr_q;
               mem_wdata_d = merged;
            end else begin
               state_d      = RESP;
               resp_valid_d = 1'b1;
               resp_rdata_d = load_ext;
            end
         end
         WR: begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         write_q      <= 1'b0;
         size_q       <= 2'b00;
         uns_q        <= 1'b0;
         off_q        <= 2'b00;
         wdata_q      <= '0;
         mem_we_q     <= 1'b0;
         mem_waddr_q  <= '0;
         mem_wdata_q  <= '0;
         mem_re_q     <= 1'b0;
         mem_raddr_q  <= '0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         write_q      <= write_d;
         size_q       <= size_d;
         uns_q        <= uns_d;
         off_q        <= off_d;
         wdata_q      <= wdata_d;
         mem_we_q     <= mem_we_d;
         mem_waddr_q  <= mem_waddr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_re_q     <= mem_re_d;
         mem_raddr_q  <= mem_raddr_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
      end
   end

   assign req_ready  = (state_q == IDLE);
   assign mem_we     = mem_we_q;
   assign mem_waddr  = mem_waddr_q;
   assign mem_wdata  = mem_wdata_q;
   assign mem_re     = mem_re_q;
   assign mem_raddr  = mem_raddr_q;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;

endmodule
